// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, absorbs the 1-cycle memory read
// latency and delivers one instruction per cycle to decode.
module imem_fetch_ctrl #(
  parameter int ADDR_W   = 11,
  parameter int DATA_W   = 32,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_dout,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt_req,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  output logic              halted,
  output logic [31:0]       fetch_count
);

  // state   | meaning
  // FLUSH   | memory is reading pc; nothing to present yet
  // RUN     | imem_dout (or the hold register) is a valid instruction
  // HALTED  | fetch stopped until reset
  typedef enum logic [1:0] {
    S_FLUSH  = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] RESET_PC_A = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] PC_ONE     = ADDR_W'(1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   ipc_q, ipc_d;
  logic [31:0]         cnt_q, cnt_d;
  logic [DATA_W-1:0]   hold_q, hold_d;
  logic                hold_vld_q, hold_vld_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_FLUSH;
      pc_q       <= RESET_PC_A;
      ipc_q      <= '0;
      cnt_q      <= '0;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ipc_q      <= ipc_d;
      cnt_q      <= cnt_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ipc_d      = ipc_q;
    cnt_d      = cnt_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    case (state_q)
      S_FLUSH: begin
        hold_vld_d = 1'b0;
        if (redirect_valid) begin
          pc_d = redirect_pc;
        end else begin
          state_d = S_RUN;
          pc_d    = pc_q + PC_ONE;
          ipc_d   = pc_q;
        end
      end
      S_RUN: begin
        if (halt_req) begin
          state_d    = S_HALTED;
          hold_vld_d = 1'b0;
        end else if (redirect_valid) begin
          state_d    = S_FLUSH;
          pc_d       = redirect_pc;
          hold_vld_d = 1'b0;
          if (!stall) cnt_d = cnt_q + 32'd1;
        end else if (stall) begin
          // memory moves on to pc while stalled, so keep the first-cycle data
          if (!hold_vld_q) begin
            hold_d     = imem_dout;
            hold_vld_d = 1'b1;
          end
        end else begin
          pc_d       = pc_q + PC_ONE;
          ipc_d      = pc_q;
          cnt_d      = cnt_q + 32'd1;
          hold_vld_d = 1'b0;
        end
      end
      S_HALTED: begin
        hold_vld_d = 1'b0;
      end
      default: begin
        state_d    = S_FLUSH;
        hold_vld_d = 1'b0;
      end
    endcase
  end

  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == S_RUN);
  assign instr       = instr_valid ? (hold_vld_q ? hold_q : imem_dout) : '0;
  assign instr_pc    = ipc_q;
  assign halted      = (state_q == S_HALTED);
  assign fetch_count = cnt_q;

endmodule
